// File: rtl/adc_lane_aligner.sv
// adc_lane_aligner
// Frame-aligns NUM_CH x LANES ISERDES word streams in the CLKDIV domain and
// interleaves each channel's lane words into one SAMPLE_W-bit sample.
// The alignment FSM settles, checks the frame-clock word, bitslips until
// the frame pattern is seen LOCK_CNT times in a row, and drops lock after
// MISS_MAX consecutive misses.
// Optional feature: define ADC_RAMP_CHECK_EN to add ramp_err_cnt_o, a
// saturating count of channel-0 ramp discontinuities on valid samples.
module adc_lane_aligner #(
  parameter int                NUM_CH    = 4,
  parameter int                LANES     = 2,
  parameter int                SER_W     = 8,
  parameter logic [SER_W-1:0]  FRAME_PAT = 8'hF0,
  parameter int                SETTLE    = 4,
  parameter int                LOCK_CNT  = 16,
  parameter int                MISS_MAX  = 4
) (
  input  logic                                CLKDIV,
  input  logic                                RST,
  input  logic                                CE,
  input  logic [SER_W-1:0]                    frm_i,
  input  logic [NUM_CH*LANES*SER_W-1:0]       lane_i,
  output logic                                bitslip_o,
  output logic                                aligned_o,
  output logic [NUM_CH*LANES*SER_W-1:0]       sample_o,
  output logic                                valid_o,
  output logic                                align_err_o,
  output logic [7:0]                          lock_loss_cnt_o
`ifdef ADC_RAMP_CHECK_EN
  ,
  output logic [15:0]                         ramp_err_cnt_o
`endif
);

  localparam int SAMPLE_W = LANES * SER_W;
  localparam int SETTLE_W = 4;
  localparam int MATCH_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W   = $clog2(MISS_MAX + 1);
  localparam int SLIP_W   = $clog2(SER_W + 1);

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED
  } state_t;

  state_t               r_state,       w_state_nxt;
  logic [SETTLE_W-1:0]  r_settle_cnt,  w_settle_nxt;
  logic [MATCH_W-1:0]   r_match_cnt,   w_match_nxt;
  logic [MISS_W-1:0]    r_miss_cnt,    w_miss_nxt;
  logic [SLIP_W-1:0]    r_slip_cnt,    w_slip_nxt;
  logic [7:0]           r_lock_loss,   w_lock_loss_nxt;
  logic                 w_bitslip;
  logic                 w_align_err;
  logic                 w_aligned;
  logic                 w_frm_match;
  logic [NUM_CH*SAMPLE_W-1:0] w_sample;
  logic [NUM_CH*SAMPLE_W-1:0] r_sample;
  logic                 r_valid;

  assign w_frm_match = (frm_i == FRAME_PAT);
  assign w_aligned   = (r_state == ST_LOCKED);

  // State and counter registers; RST wins over CE, CE low holds everything.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLKDIV) begin
    if (RST) begin
      r_state      <= ST_SETTLE;
      r_settle_cnt <= '0;
      r_match_cnt  <= '0;
      r_miss_cnt   <= '0;
      r_slip_cnt   <= '0;
      r_lock_loss  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_match_cnt  <= w_match_nxt;
      r_miss_cnt   <= w_miss_nxt;
      r_slip_cnt   <= w_slip_nxt;
      r_lock_loss  <= w_lock_loss_nxt;
    end
  end

  // Next-state, counter updates and the one-cycle bitslip/error pulses.
  // NOTE: every signal gets a default at the top so no path infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_settle_nxt    = r_settle_cnt;
    w_match_nxt     = r_match_cnt;
    w_miss_nxt      = r_miss_cnt;
    w_slip_nxt      = r_slip_cnt;
    w_lock_loss_nxt = r_lock_loss;
    w_bitslip       = 1'b0;
    w_align_err     = 1'b0;
    if (CE && !RST) begin
      case (r_state)
        ST_SETTLE: begin
          if (r_settle_cnt == SETTLE_W'(SETTLE - 1)) begin
            w_settle_nxt = '0;
            w_state_nxt  = ST_CHECK;
          end else begin
            w_settle_nxt = r_settle_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_frm_match) begin
            if (r_match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
              w_match_nxt = '0;
              w_miss_nxt  = '0;
              w_slip_nxt  = '0;
              w_state_nxt = ST_LOCKED;
            end else begin
              w_match_nxt = r_match_cnt + 1'b1;
            end
          end else begin
            w_match_nxt = '0;
            w_state_nxt = ST_SLIP;
          end
        end
        ST_SLIP: begin
          // Slip exactly once, then re-settle; SLIP is never entered twice
          // in a row so bitslip cannot pulse on consecutive cycles.
          w_bitslip    = 1'b1;
          w_settle_nxt = '0;
          w_state_nxt  = ST_SETTLE;
          if (r_slip_cnt == SLIP_W'(SER_W - 1)) begin
            w_slip_nxt  = '0;
            w_align_err = 1'b1;
          end else begin
            w_slip_nxt  = r_slip_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_frm_match) begin
            w_miss_nxt = '0;
          end else if (r_miss_cnt == MISS_W'(MISS_MAX - 1)) begin
            // Lock loss re-checks without slipping: the phase was good.
            w_miss_nxt  = '0;
            w_match_nxt = '0;
            w_state_nxt = ST_CHECK;
            if (r_lock_loss != 8'hFF) begin
              w_lock_loss_nxt = r_lock_loss + 8'd1;
            end
          end else begin
            w_miss_nxt = r_miss_cnt + 1'b1;
          end
        end
        default: w_state_nxt = ST_SETTLE;
      endcase
    end
  end

  // Interleave: bit k of lane l lands at SAMPLE_W-1-(k*LANES + LANES-1-l).
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      for (genvar k = 0; k < SER_W; k++) begin : g_bit
        assign w_sample[c*SAMPLE_W + SAMPLE_W-1-(k*LANES + (LANES-1-l))] =
          lane_i[(c*LANES + l)*SER_W + k];
      end
    end
  end

  // Sample register follows lane_i on every enabled cycle; valid tracks lock.
  always_ff @(posedge CLKDIV) begin
    if (RST) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (CE) begin
        r_sample <= w_sample;
      end
      r_valid <= w_aligned & CE;
    end
  end

`ifdef ADC_RAMP_CHECK_EN
  logic [SAMPLE_W-1:0] r_ramp_prev;
  logic                r_ramp_ref;
  logic [15:0]         r_ramp_err_cnt;

  // Channel-0 ramp monitor; the first valid sample of each lock is a reference.
  always_ff @(posedge CLKDIV) begin
    if (RST) begin
      r_ramp_prev    <= '0;
      r_ramp_ref     <= 1'b0;
      r_ramp_err_cnt <= '0;
    end else if (r_valid) begin
      if (r_ramp_ref && (r_sample[SAMPLE_W-1:0] != r_ramp_prev + 1'b1) &&
          (r_ramp_err_cnt != 16'hFFFF)) begin
        r_ramp_err_cnt <= r_ramp_err_cnt + 16'd1;
      end
      r_ramp_prev <= r_sample[SAMPLE_W-1:0];
      r_ramp_ref  <= 1'b1;
    end else if (!w_aligned) begin
      r_ramp_ref <= 1'b0;
    end
  end

  assign ramp_err_cnt_o = r_ramp_err_cnt;
`endif

  assign bitslip_o       = w_bitslip;
  assign align_err_o     = w_align_err;
  assign aligned_o       = w_aligned;
  assign sample_o        = r_sample;
  assign valid_o         = r_valid;
  assign lock_loss_cnt_o = r_lock_loss;

endmodule

// File: tb/tb_adc_lane_aligner.sv
// Self-checking bench for adc_lane_aligner: randomised lane data and
// frame words against a behavioural model of the alignment procedure.
module tb_adc_lane_aligner;

  localparam int          NUM_CH    = 4;
  localparam int          LANES     = 2;
  localparam int          SER_W     = 8;
  localparam int          SAMPLE_W  = LANES * SER_W;
  localparam logic [7:0]  FRAME_PAT = 8'hF0;
  localparam int          SETTLE    = 4;
  localparam int          LOCK_CNT  = 16;
  localparam int          MISS_MAX  = 4;
  localparam int          LW        = NUM_CH * LANES * SER_W;
  localparam int          SW        = NUM_CH * SAMPLE_W;

  logic          CLKDIV = 1'b0;
  logic          RST;
  logic          CE;
  logic [7:0]    frm_i;
  logic [LW-1:0] lane_i;
  logic          bitslip_o;
  logic          aligned_o;
  logic [SW-1:0] sample_o;
  logic          valid_o;
  logic          align_err_o;
  logic [7:0]    lock_loss_cnt_o;

  adc_lane_aligner #(
    .NUM_CH(NUM_CH), .LANES(LANES), .SER_W(SER_W), .FRAME_PAT(FRAME_PAT),
    .SETTLE(SETTLE), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)
  ) dut (
    .CLKDIV(CLKDIV), .RST(RST), .CE(CE), .frm_i(frm_i), .lane_i(lane_i),
    .bitslip_o(bitslip_o), .aligned_o(aligned_o), .sample_o(sample_o),
    .valid_o(valid_o), .align_err_o(align_err_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  always #5 CLKDIV = ~CLKDIV;

  int n_checks = 0;
  int n_pass   = 0;

  // Inputs applied this cycle, kept for the model.
  bit            d_rst;
  bit            d_ce;
  logic [7:0]    d_frm;
  logic [LW-1:0] d_lanes;

  // Behavioural model of the alignment procedure.
  int            m_settle_left;  // settle cycles still owed before checking
  int            m_hits;         // consecutive frame matches while hunting
  int            m_misses;       // consecutive misses while locked
  int            m_slips;        // slips since last lock/reset (not wrapped)
  int            m_losses;
  bit            m_locked;
  bit            m_slip_due;
  bit            m_valid;
  logic [SW-1:0] m_sample;

  function automatic logic [SW-1:0] ref_interleave(input logic [LW-1:0] lanes);
    logic [SW-1:0] s;
    s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < SAMPLE_W; j++) begin
        // j counts sample bits from the MSB: lanes alternate high lane first.
        int k;
        int l;
        k = j / LANES;
        l = LANES - 1 - (j % LANES);
        s[c*SAMPLE_W + SAMPLE_W - 1 - j] = lanes[(c*LANES + l)*SER_W + k];
      end
    end
    return s;
  endfunction

  function automatic void model_advance();
    if (d_rst) begin
      m_settle_left = SETTLE;
      m_hits = 0; m_misses = 0; m_slips = 0; m_losses = 0;
      m_locked = 0; m_slip_due = 0; m_valid = 0; m_sample = '0;
      return;
    end
    m_valid = m_locked && d_ce;
    if (!d_ce) return;
    m_sample = ref_interleave(d_lanes);
    if (m_slip_due) begin
      m_slip_due    = 0;
      m_slips       = m_slips + 1;
      m_settle_left = SETTLE;
    end else if (m_settle_left > 0) begin
      m_settle_left = m_settle_left - 1;
    end else if (m_locked) begin
      if (d_frm == FRAME_PAT) m_misses = 0;
      else begin
        m_misses = m_misses + 1;
        if (m_misses == MISS_MAX) begin
          m_locked = 0; m_misses = 0; m_hits = 0;
          if (m_losses < 255) m_losses = m_losses + 1;
        end
      end
    end else begin
      if (d_frm == FRAME_PAT) begin
        m_hits = m_hits + 1;
        if (m_hits == LOCK_CNT) begin
          m_locked = 1; m_hits = 0; m_misses = 0; m_slips = 0;
        end
      end else begin
        m_hits = 0;
        m_slip_due = 1;
      end
    end
  endfunction

  function automatic bit exp_bitslip();
    return !d_rst && d_ce && m_slip_due;
  endfunction

  function automatic bit exp_err();
    return exp_bitslip() && (((m_slips + 1) % SER_W) == 0);
  endfunction

  function automatic logic [SW+11:0] exp_vec();
    return {exp_bitslip(), m_locked, m_valid, exp_err(), 8'(m_losses), m_sample};
  endfunction

  function automatic logic [SW+11:0] obs_vec();
    return {bitslip_o, aligned_o, valid_o, align_err_o, lock_loss_cnt_o, sample_o};
  endfunction

  function automatic logic [LW-1:0] rnd_lanes();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [7:0] rnd_miss();
    logic [7:0] v;
    v = 8'($urandom());
    if (v == FRAME_PAT) v = ~v;
    return v;
  endfunction

  task automatic drive(input bit rst, input bit ce, input logic [7:0] frm,
                       input logic [LW-1:0] lanes);
    d_rst = rst; d_ce = ce; d_frm = frm; d_lanes = lanes;
    RST = rst; CE = ce; frm_i = frm; lane_i = lanes;
    #1;
  endtask

  task automatic tick();
    @(posedge CLKDIV);
    model_advance();
    @(negedge CLKDIV);
  endtask

  task automatic apply_reset();
    drive(1, 1, FRAME_PAT, rnd_lanes());
    tick();
  endtask

  task automatic test_reset();
    int rise;
    int vrise;
    drive(1, 1, FRAME_PAT, '0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, FRAME_PAT, rnd_lanes());
      n_checks++;
      if (obs_vec() !== '0)
        $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, obs_vec());
      else n_pass++;
      tick();
    end
    rise = -1; vrise = -1;
    for (int n = 0; n < 30; n++) begin
      drive(0, 1, FRAME_PAT, rnd_lanes());
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL reset_run cyc=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
      else n_pass++;
      if (aligned_o && rise < 0) rise = n;
      if (valid_o && vrise < 0) vrise = n;
      tick();
    end
    n_checks++;
    if (rise !== SETTLE + LOCK_CNT)
      $display("FAIL lock_latency got=%0d exp=%0d", rise, SETTLE + LOCK_CNT);
    else n_pass++;
    n_checks++;
    if (vrise !== SETTLE + LOCK_CNT + 1)
      $display("FAIL valid_latency got=%0d exp=%0d", vrise, SETTLE + LOCK_CNT + 1);
    else n_pass++;
  endtask

  task automatic test_slip_hunt();
    logic [7:0] frm;
    int slips, errs, last, min_gap, lock_at, b2b;
    bit prev_bs, bs_now;
    apply_reset();
    frm = 8'h0F; slips = 0; errs = 0; last = -1000; min_gap = 1000;
    lock_at = -1; b2b = 0; prev_bs = 0;
    for (int n = 0; n < 200 && lock_at < 0; n++) begin
      drive(0, 1, frm, rnd_lanes());
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL hunt_cycle cyc=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
      else n_pass++;
      bs_now = bitslip_o;
      if (bs_now) begin
        slips++;
        if (n - last < min_gap) min_gap = n - last;
        last = n;
        if (prev_bs) b2b++;
      end
      prev_bs = bs_now;
      if (align_err_o) errs++;
      if (aligned_o) lock_at = n;
      tick();
      if (bs_now) frm = {frm[6:0], frm[7]};
    end
    n_checks++;
    if (lock_at < 0) $display("FAIL hunt_lock got=unlocked exp=locked");
    else n_pass++;
    n_checks++;
    if (slips !== 4) $display("FAIL hunt_slips got=%0d exp=4", slips);
    else n_pass++;
    n_checks++;
    if (errs !== 0) $display("FAIL hunt_align_err got=%0d exp=0", errs);
    else n_pass++;
    n_checks++;
    if (min_gap < SETTLE + 1 || b2b !== 0)
      $display("FAIL hunt_spacing got=%0d b2b=%0d exp>=%0d", min_gap, b2b, SETTLE + 1);
    else n_pass++;
  endtask

  task automatic test_exhaustion();
    int slips, errs, seen_lock, b2b;
    bit prev_bs;
    apply_reset();
    slips = 0; errs = 0; seen_lock = 0; b2b = 0; prev_bs = 0;
    for (int n = 0; n < 120; n++) begin
      drive(0, 1, 8'hAA, rnd_lanes());
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL exhaust_cycle cyc=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
      else n_pass++;
      if (bitslip_o) begin
        slips++;
        if (prev_bs) b2b++;
      end
      prev_bs = bitslip_o;
      if (align_err_o) begin
        errs++;
        n_checks++;
        if (slips % SER_W !== 0)
          $display("FAIL exhaust_err_slot got=slip%0d exp=multiple of %0d", slips, SER_W);
        else n_pass++;
      end
      if (aligned_o) seen_lock++;
      tick();
    end
    n_checks++;
    if (slips < 9 || errs !== slips / SER_W)
      $display("FAIL exhaust_counts got=slips%0d errs%0d exp=errs%0d", slips, errs, slips / SER_W);
    else n_pass++;
    n_checks++;
    if (seen_lock !== 0 || b2b !== 0)
      $display("FAIL exhaust_no_lock got=lock%0d b2b%0d exp=0", seen_lock, b2b);
    else n_pass++;
  endtask

  task automatic test_lock_loss();
    bit pat [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    int bs;
    apply_reset();
    for (int n = 0; n < SETTLE + LOCK_CNT + 2; n++) begin
      drive(0, 1, FRAME_PAT, rnd_lanes());
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL ll_acquire cyc=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
      else n_pass++;
      tick();
    end
    n_checks++;
    if (aligned_o !== 1'b1) $display("FAIL ll_locked got=%b exp=1", aligned_o);
    else n_pass++;
    bs = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, pat[i] ? FRAME_PAT : rnd_miss(), rnd_lanes());
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL ll_cycle cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
      if (bitslip_o) bs++;
      tick();
      if (i == 3) begin
        n_checks++;
        if (aligned_o !== 1'b1) $display("FAIL ll_hold got=%b exp=1", aligned_o);
        else n_pass++;
      end
    end
    n_checks++;
    if (aligned_o !== 1'b0 || lock_loss_cnt_o !== 8'd1 || bs !== 0)
      $display("FAIL ll_drop got=aligned%b loss%0d slips%0d exp=aligned0 loss1 slips0",
               aligned_o, lock_loss_cnt_o, bs);
    else n_pass++;
    for (int n = 0; n < LOCK_CNT + 2; n++) begin
      drive(0, 1, FRAME_PAT, rnd_lanes());
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL ll_relock cyc=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
      else n_pass++;
      tick();
    end
    drive(1, 1, FRAME_PAT, rnd_lanes());
    tick();
    n_checks++;
    if (aligned_o !== 1'b0 || lock_loss_cnt_o !== 8'd0)
      $display("FAIL rst_mid_lock got=aligned%b loss%0d exp=aligned0 loss0",
               aligned_o, lock_loss_cnt_o);
    else n_pass++;
  endtask

  task automatic test_interleave();
    logic [LW-1:0] v;
    v = '0;
    v[(2*LANES + 1)*SER_W +: SER_W] = 8'h80;
    drive(0, 1, FRAME_PAT, v);
    tick();
    n_checks++;
    if (sample_o !== {16'h0000, 16'h0002, 16'h0000, 16'h0000})
      $display("FAIL il_lane1_msb got=%h exp=ch2 0002", sample_o);
    else n_pass++;
    v = '0;
    v[(2*LANES + 0)*SER_W +: SER_W] = 8'h01;
    drive(0, 1, FRAME_PAT, v);
    tick();
    n_checks++;
    if (sample_o[2*SAMPLE_W +: SAMPLE_W] !== 16'h4000)
      $display("FAIL il_lane0_lsb got=%h exp=4000", sample_o[2*SAMPLE_W +: SAMPLE_W]);
    else n_pass++;
    for (int n = 0; n < 24; n++) begin
      drive(0, 1, FRAME_PAT, rnd_lanes());
      tick();
      n_checks++;
      if (sample_o !== m_sample)
        $display("FAIL il_random cyc=%0d got=%h exp=%h", n, sample_o, m_sample);
      else n_pass++;
    end
  endtask

  task automatic test_ce();
    int rise;
    int matched;
    apply_reset();
    matched = 5;
    for (int n = 0; n < SETTLE + matched; n++) begin
      drive(0, 1, FRAME_PAT, rnd_lanes());
      tick();
    end
    for (int n = 0; n < 10; n++) begin
      drive(0, 0, rnd_miss(), rnd_lanes());
      n_checks++;
      if (obs_vec() !== exp_vec() || valid_o !== 1'b0 || bitslip_o !== 1'b0)
        $display("FAIL ce_freeze cyc=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
      else n_pass++;
      tick();
    end
    rise = -1;
    for (int n = 0; n < 40 && rise < 0; n++) begin
      drive(0, 1, FRAME_PAT, rnd_lanes());
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL ce_resume cyc=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
      else n_pass++;
      if (aligned_o) rise = n;
      tick();
    end
    n_checks++;
    if (rise !== LOCK_CNT - matched)
      $display("FAIL ce_lock_latency got=%0d exp=%0d", rise, LOCK_CNT - matched);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_slip_hunt();
    test_exhaustion();
    test_lock_loss();
    test_interleave();
    test_ce();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
